crc_stream: RTL and testbench

//   Framed, multi-byte-lane CRC engine: successor to the single-word parallel CRC.
//   - Consumes a valid/ready byte stream H bits wide, LSB-first lanes, with a frame-end marker.
//   - Emits one result per frame: the final CRC and a residue check flag.
//   - The residue check verifies frames that carry their own trailing FCS.
//   - Sits between MAC/packetiser datapaths and frame-status logic; one instance serves both TX generation and RX checking.

---
 rtl/crc_stream.sv | 71 +++++++
 tb/tb_crc_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/crc_stream.sv
// crc_stream: framed multi-lane reflected CRC engine with one-result-per-frame handshake
// and trailing-FCS residue check.
module crc_stream #(
    parameter int H = 32,
    parameter int W = 32,
    parameter logic [W-1:0] P = 'hEDB88320,
    parameter logic [W-1:0] INIT = {W{1'b1}},
    parameter logic [W-1:0] XOROUT = {W{1'b1}},
    parameter logic [W-1:0] RESIDUE = 'hDEBB20E3,
    localparam int L = H / 8,
    localparam int B = (L > 1) ? $clog2(L) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [H-1:0] d,
    input  logic         last,
    input  logic [B-1:0] nbytes,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] crc,
    output logic         ok
);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    function automatic logic [W-1:0] step(input logic [W-1:0] a, input logic b);
        return (a >> 1) ^ ((a[0] ^ b) ? P : '0);
    endfunction

    logic [0:0]   state;
    logic [W-1:0] q;
    logic [W-1:0] tap [0:H];
    logic [W-1:0] last_tap;

    assign tap[0] = q;
    for (genvar i = 0; i < H; i++) begin : g_bit
        assign tap[i+1] = step(tap[i], d[i]);
    end

    // Byte-boundary tap for the final beat; out-of-range nbytes falls back to a full beat.
    always_comb begin
        last_tap = tap[H];
        for (int k = 0; k < L; k++)
            if (int'(nbytes) == k) last_tap = tap[8*(k+1)];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= INIT;
            state <= RUN;
        end else if (state == RUN) begin
            if (abort) begin
                q <= INIT;
            end else if (in_valid) begin
                q <= last ? last_tap : tap[H];
                if (last) state <= HOLD;
            end
        end else if (out_ready) begin
            q <= INIT;
            state <= RUN;
        end
    end

    assign in_ready = (state == RUN);
    assign out_valid = (state == HOLD);
    assign crc = q ^ XOROUT;
    assign ok = (q == RESIDUE);
endmodule

// File: tb/tb_crc_stream.sv
// tb_crc_stream: directed and randomized checks of crc_stream at H=8 and H=32 against a
// table-driven byte-wise CRC-32 reference.
module tb_crc_stream;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic v8, r8, l8, a8, ov8, or8, ok8;
    logic [7:0] d8;
    logic [0:0] nb8;
    logic [31:0] c8;
    logic v32, r32, l32, a32, ov32, or32, ok32;
    logic [31:0] d32, c32;
    logic [1:0] nb32;

    int total = 0;
    int passed = 0;
    logic [31:0] tbl [256];
    logic [7:0] q9 [$];

    crc_stream #(.H(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8), .d(d8), .last(l8),
        .nbytes(nb8), .abort(a8), .out_valid(ov8), .out_ready(or8), .crc(c8), .ok(ok8)
    );

    crc_stream #(.H(32)) u32 (
        .clk(clk), .reset(reset), .in_valid(v32), .in_ready(r32), .d(d32), .last(l32),
        .nbytes(nb32), .abort(a32), .out_valid(ov32), .out_ready(or32), .crc(c32), .ok(ok32)
    );

    // Register value (before XOROUT) after processing the byte sequence from INIT.
    function automatic logic [31:0] reg_of(input logic [7:0] b [$]);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        foreach (b[i]) r = (r >> 8) ^ tbl[r[7:0] ^ b[i]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic put8(input logic [7:0] dd, input bit ll);
        int t;
        t = 0;
        v8 = 1'b1; d8 = dd; l8 = ll; nb8 = 1'($urandom);
        while (!r8 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("put8.timeout", 0, 1);
        @(negedge clk);
        v8 = 1'b0; l8 = 1'b0; d8 = 8'($urandom);
    endtask

    task automatic put32(input logic [31:0] dd, input bit ll, input logic [1:0] nb);
        int t;
        t = 0;
        v32 = 1'b1; d32 = dd; l32 = ll; nb32 = nb;
        while (!r32 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("put32.timeout", 0, 1);
        @(negedge clk);
        v32 = 1'b0; l32 = 1'b0; d32 = $urandom;
    endtask

    task automatic send8(input logic [7:0] f [$], input bit gaps);
        foreach (f[i]) begin
            put8(f[i], i == f.size() - 1);
            if (gaps && i != f.size() - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // Packs bytes LSB-first into 4-lane beats; unused lanes of the last beat get garbage.
    task automatic send32(input logic [7:0] f [$], input bit gaps);
        int n, k;
        logic [31:0] w;
        n = f.size();
        for (int i = 0; i < n; i += 4) begin
            w = $urandom;
            k = (n - i > 4) ? 4 : n - i;
            for (int j = 0; j < k; j++) w[8*j +: 8] = f[i+j];
            put32(w, i + 4 >= n, (i + 4 >= n) ? 2'(k - 1) : 2'($urandom));
            if (gaps && i + 4 < n) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic res(input bit w, input string tag, input logic [31:0] ec, input bit eok,
                       input int hold, input bit ab);
        chk({tag, ".valid"}, w ? ov32 : ov8, 1);
        chk({tag, ".crc"}, w ? c32 : c8, ec);
        chk({tag, ".ok"}, w ? ok32 : ok8, eok);
        chk({tag, ".busy"}, w ? r32 : r8, 0);
        repeat (hold) begin
            if (w) begin a32 = ab; v32 = ab; end else begin a8 = ab; v8 = ab; end
            @(negedge clk);
            chk({tag, ".hold_valid"}, w ? ov32 : ov8, 1);
            chk({tag, ".hold_crc"}, w ? c32 : c8, ec);
            chk({tag, ".hold_busy"}, w ? r32 : r8, 0);
        end
        if (w) begin a32 = 0; v32 = 0; or32 = 1; end else begin a8 = 0; v8 = 0; or8 = 1; end
        @(negedge clk);
        or32 = 0; or8 = 0;
        chk({tag, ".taken"}, w ? ov32 : ov8, 0);
        chk({tag, ".ready"}, w ? r32 : r8, 1);
    endtask

    initial begin
        logic [7:0] f [$];
        logic [31:0] r, c;
        int idx;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            repeat (8) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
            tbl[i] = c;
        end
        q9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        {v8, l8, a8, or8, d8, nb8} = '0;
        {v32, l32, a32, or32, d32, nb32} = '0;
        repeat (2) @(negedge clk);
        chk("rst.ready8", r8, 1);
        chk("rst.valid8", ov8, 0);
        chk("rst.crc8", c8, 0);
        chk("rst.ok8", ok8, 0);
        chk("rst.ready32", r32, 1);
        chk("rst.valid32", ov32, 0);
        chk("rst.crc32", c32, 0);
        chk("rst.ok32", ok32, 0);
        reset = 1'b0;
        @(negedge clk);

        send8(q9, 0);
        res(0, "t1", 32'hCBF43926, 0, 0, 0);

        put32(32'h34333231, 0, 2'd3);
        put32(32'h38373635, 0, 2'd1);
        put32(32'h00000039, 1, 2'd0);
        res(1, "t2", 32'hCBF43926, 0, 0, 0);
        put32(32'h34333231, 0, 2'd0);
        put32(32'h38373635, 0, 2'd2);
        put32(32'hA5C3E739, 1, 2'd0);
        res(1, "t2g", 32'hCBF43926, 0, 0, 0);

        f = q9;
        f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(8'hCB);
        send32(f, 0);
        res(1, "t3", 32'h2144DF1C, 1, 0, 0);
        f[0] = 8'h30;
        r = reg_of(f);
        send32(f, 0);
        res(1, "t3f", r ^ 32'hFFFFFFFF, 0, 0, 0);

        send32(q9, 0);
        res(1, "t4", 32'hCBF43926, 0, 5, 0);
        send32(q9, 0);
        res(1, "t4n", 32'hCBF43926, 0, 0, 0);

        put8(8'h31, 0);
        put8(8'h32, 0);
        v8 = 1; d8 = 8'h33; a8 = 1;
        @(negedge clk);
        v8 = 0; a8 = 0;
        send8(q9, 0);
        res(0, "t5", 32'hCBF43926, 0, 2, 1);
        put32(32'h34333231, 0, 2'd0);
        v32 = 1; d32 = 32'h38373635; a32 = 1; l32 = 1;
        @(negedge clk);
        v32 = 0; a32 = 0; l32 = 0;
        send32(q9, 0);
        res(1, "t5w", 32'hCBF43926, 0, 0, 0);

        put32(32'h34333231, 0, 2'd0);
        #2 reset = 1'b1;
        #1;
        chk("t6a.ready", r32, 1);
        chk("t6a.valid", ov32, 0);
        chk("t6a.crc", c32, 0);
        chk("t6a.ok", ok32, 0);
        @(negedge clk);
        reset = 1'b0;
        send32(q9, 0);
        #2 reset = 1'b1;
        #1;
        chk("t6b.ready", r32, 1);
        chk("t6b.valid", ov32, 0);
        chk("t6b.crc", c32, 0);
        @(negedge clk);
        reset = 1'b0;
        send32(q9, 0);
        res(1, "t6c", 32'hCBF43926, 0, 0, 0);

        for (int n = 0; n < 50; n++) begin
            f = {};
            repeat ($urandom_range(1, 16)) f.push_back(8'($urandom));
            if ($urandom_range(0, 1)) begin
                c = reg_of(f) ^ 32'hFFFFFFFF;
                for (int j = 0; j < 4; j++) f.push_back(c[8*j +: 8]);
                if ($urandom_range(0, 3) == 0) begin
                    idx = $urandom_range(0, f.size() - 1);
                    f[idx] = f[idx] ^ 8'(1 << $urandom_range(0, 7));
                end
            end
            r = reg_of(f);
            if (n < 40) begin
                send32(f, 1);
                res(1, "rnd32", r ^ 32'hFFFFFFFF, r == 32'hDEBB20E3, $urandom_range(0, 3), 1'($urandom));
            end else begin
                send8(f, 1);
                res(0, "rnd8", r ^ 32'hFFFFFFFF, r == 32'hDEBB20E3, $urandom_range(0, 3), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
